// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the two-port memory arbiter slice:
//   req_id_t    - identifies a requester (instruction fetch or load/store)
//   arb_state_t - arbiter FSM states
//   other_req() - returns the requester that is not the given one
// Default widths are provided for integrators that want them.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } req_id_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } arb_state_t;

  // The requester opposite to the one passed in.
  function automatic req_id_t other_req(input req_id_t id);
    req_id_t res;
    case (id)
      REQ_IMEM: res = REQ_DMEM;
      REQ_DMEM: res = REQ_IMEM;
      default:  res = REQ_IMEM;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Chooses which requester drives the shared memory port this cycle.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - on simultaneous requests the requester not granted last wins
//   undefined - fixed priority, dmem always wins (last_grant is ignored)
// Ports:
//   imem_req, dmem_req : request lines of the two requesters
//   last_grant         : requester that won the most recent handshake
//   lock               : previous cycle presented a request that was not granted
//   held               : requester that was presented in that previous cycle
//   sel                : selected requester (meaningful only when a req is high)
// ---------------------------------------------------------------------------
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic    imem_req,
  input  logic    dmem_req,
  input  req_id_t last_grant,
  input  logic    lock,
  input  req_id_t held,
  output req_id_t sel
);

  logic held_still_req_s;

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant_s;
  assign unused_last_grant_s = ^last_grant;
`endif

  // A request left waiting for grant keeps ownership of the port so the
  // payload on the memory side never swaps mid-request.
  assign held_still_req_s = (held == REQ_DMEM) ? dmem_req : imem_req;

  // Selection: locked requester first, then arbitration among live requests.
  always_comb begin
    sel = REQ_IMEM;
    if (lock && held_still_req_s) begin
      sel = held;
    end else if (imem_req && dmem_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      sel = other_req(last_grant);
`else
      sel = REQ_DMEM;
`endif
    end else if (dmem_req) begin
      sel = REQ_DMEM;
    end else begin
      sel = REQ_IMEM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory port with at most one transaction outstanding.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on contention;
// default build uses fixed priority with dmem winning).
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   imem_req_i, imem_addr_i            : fetch request
//   imem_gnt_o, imem_rvalid_o, imem_rdata_o : fetch grant / response
//   dmem_req_i, dmem_we_i, dmem_be_i, dmem_addr_i, dmem_wdata_i : load/store request
//   dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o : load/store grant / response
//   mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o : shared memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i    : shared memory grant / response
//   busy_o                             : a granted transaction awaits its response
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [DATA_W-1:0]   imem_rdata_o,

  input  logic                dmem_req_i,
  input  logic                dmem_we_i,
  input  logic [DATA_W/8-1:0] dmem_be_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                busy_o
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state_r;
  req_id_t    owner_r;
  req_id_t    held_r;
  logic       lock_r;
  logic       busy_r;

  req_id_t    sel_s;
  req_id_t    last_grant_s;
  logic       issue_ok_s;
  logic       req_on_s;
  logic       handshake_s;
  logic       rsp_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t    last_grant_r;
  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = REQ_IMEM;
`endif

  mem_arb_pick u_pick (
    .imem_req   (imem_req_i),
    .dmem_req   (dmem_req_i),
    .last_grant (last_grant_s),
    .lock       (lock_r),
    .held       (held_r),
    .sel        (sel_s)
  );

  // Issue window: idle, or the cycle the outstanding response returns.
  // Reset closes the window so nothing leaves the arbiter while in reset.
  always_comb begin
    issue_ok_s = 1'b0;
    rsp_s      = 1'b0;
    if (rst_i) begin
      issue_ok_s = 1'b0;
      rsp_s      = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          issue_ok_s = 1'b1;
          rsp_s      = 1'b0;
        end
        WAIT_RSP: begin
          issue_ok_s = mem_rvalid_i;
          rsp_s      = mem_rvalid_i;
        end
        default: begin
          issue_ok_s = 1'b0;
          rsp_s      = 1'b0;
        end
      endcase
    end
  end

  assign req_on_s    = issue_ok_s & (imem_req_i | dmem_req_i);
  assign handshake_s = req_on_s & mem_gnt_i;

  // Memory-side request mux and requester-side grant/response routing.
  always_comb begin
    mem_req_o     = req_on_s;
    mem_we_o      = 1'b0;
    mem_be_o      = {BE_W{1'b0}};
    mem_addr_o    = {ADDR_W{1'b0}};
    mem_wdata_o   = {DATA_W{1'b0}};
    imem_gnt_o    = 1'b0;
    dmem_gnt_o    = 1'b0;
    imem_rvalid_o = 1'b0;
    dmem_rvalid_o = 1'b0;

    if (req_on_s) begin
      case (sel_s)
        REQ_DMEM: begin
          mem_we_o    = dmem_we_i;
          mem_be_o    = dmem_be_i;
          mem_addr_o  = dmem_addr_i;
          mem_wdata_o = dmem_wdata_i;
          dmem_gnt_o  = mem_gnt_i;
        end
        REQ_IMEM: begin
          // Fetches are always full-word reads.
          mem_we_o    = 1'b0;
          mem_be_o    = {BE_W{1'b1}};
          mem_addr_o  = imem_addr_i;
          mem_wdata_o = {DATA_W{1'b0}};
          imem_gnt_o  = mem_gnt_i;
        end
        default: begin
          mem_we_o    = 1'b0;
        end
      endcase
    end else begin
      mem_we_o = 1'b0;
    end

    // Response belongs to whoever owned the outstanding transaction, even
    // when a new handshake to the other requester happens in the same cycle.
    if (rsp_s) begin
      imem_rvalid_o = (owner_r == REQ_IMEM);
      dmem_rvalid_o = (owner_r == REQ_DMEM);
    end else begin
      imem_rvalid_o = 1'b0;
      dmem_rvalid_o = 1'b0;
    end
  end

  // Read data is broadcast; consumers qualify it with their rvalid.
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;
  assign busy_o       = busy_r;

  // Arbiter FSM, transaction owner, request lock and grant history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      owner_r      <= REQ_IMEM;
      held_r       <= REQ_IMEM;
      lock_r       <= 1'b0;
      busy_r       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_r <= REQ_IMEM;
`endif
    end else begin
      if (handshake_s) begin
        state_r      <= WAIT_RSP;
        busy_r       <= 1'b1;
        owner_r      <= sel_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_r <= sel_s;
`endif
      end else if (rsp_s) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        state_r <= state_r;
        busy_r  <= busy_r;
      end
      // Remember an ungranted request so selection is frozen next cycle.
      lock_r <= req_on_s & ~mem_gnt_i;
      held_r <= sel_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus for mem_port_arbiter. A transaction-level model checks
// every output on every falling edge; the directed sequence adds literal
// expectations for the reference scenarios.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          igt, irv;
  logic [DW-1:0] irdata;
  logic          dreq, dwe;
  logic [BW-1:0] dbe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dgt, drv;
  logic [DW-1:0] drdata;
  logic          mreq, mwe;
  logic [BW-1:0] mbe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          mgnt, mrv;
  logic [DW-1:0] mrdata;
  logic          busy;

  int n_total = 0;
  int n_pass  = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_i(ireq), .imem_addr_i(iaddr),
    .imem_gnt_o(igt), .imem_rvalid_o(irv), .imem_rdata_o(irdata),
    .dmem_req_i(dreq), .dmem_we_i(dwe), .dmem_be_i(dbe),
    .dmem_addr_i(daddr), .dmem_wdata_i(dwdata),
    .dmem_gnt_o(dgt), .dmem_rvalid_o(drv), .dmem_rdata_o(drdata),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: one outstanding transaction, owner, last winner and a
  // pending (presented but ungranted) requester. Ids: 0 = imem, 1 = dmem.
  int m_busy  = 0;
  int m_owner = 0;
  int m_last  = 0;
  int m_pend  = -1;

  always @(negedge clk) begin : model_cmp
    int sel;
    bit can, er, hs;
    can = !rst && (m_busy == 0 || mrv);
    if (m_pend >= 0 && (m_pend == 1 ? dreq : ireq)) sel = m_pend;
    else if (ireq && dreq) sel = RR ? (m_last == 1 ? 0 : 1) : 1;
    else sel = dreq ? 1 : 0;
    er = can && (ireq || dreq);
    hs = er && mgnt;

    chk("mem_req",     mreq,   er);
    chk("mem_we",      mwe,    er && sel == 1 && dwe);
    chk("mem_be",      mbe,    !er ? 0 : (sel == 1 ? dbe : 4'hF));
    chk("mem_addr",    maddr,  !er ? 0 : (sel == 1 ? daddr : iaddr));
    chk("mem_wdata",   mwdata, (er && sel == 1) ? dwdata : 0);
    chk("imem_gnt",    igt,    hs && sel == 0);
    chk("dmem_gnt",    dgt,    hs && sel == 1);
    chk("imem_rvalid", irv,    !rst && m_busy == 1 && mrv && m_owner == 0);
    chk("dmem_rvalid", drv,    !rst && m_busy == 1 && mrv && m_owner == 1);
    chk("imem_rdata",  irdata, mrdata);
    chk("dmem_rdata",  drdata, mrdata);
    chk("busy",        busy,   m_busy);

    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 0; m_pend = -1;
    end else begin
      if (hs) begin
        m_busy = 1; m_owner = sel; m_last = sel;
      end else if (m_busy == 1 && mrv) begin
        m_busy = 0;
      end
      m_pend = (er && !mgnt) ? sel : -1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int grants[4];
  int exp_g[4];

  initial begin
    rst = 1'b1; ireq = 1'b1; iaddr = 32'h100; dreq = 1'b0; dwe = 1'b0;
    dbe = 4'h0; daddr = 32'h0; dwdata = 32'h0; mgnt = 1'b1; mrv = 1'b0;
    mrdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    // still in reset with a live request and grant
    chk("rst_mem_req", mreq, 1'b0);
    chk("rst_imem_gnt", igt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0; ireq = 1'b0; mgnt = 1'b0;
    cyc();

    // single fetch
    ireq = 1'b1; iaddr = 32'h100; mgnt = 1'b1; #2;
    chk("f_gnt", igt, 1'b1); chk("f_addr", maddr, 32'h100);
    chk("f_be", mbe, 4'hF); chk("f_we", mwe, 1'b0); chk("f_dgnt", dgt, 1'b0);
    cyc();
    ireq = 1'b0; mgnt = 1'b0; mrv = 1'b1; mrdata = 32'hDEADBEEF; #2;
    chk("f_rvalid", irv, 1'b1); chk("f_rdata", irdata, 32'hDEADBEEF);
    chk("f_drvalid", drv, 1'b0); chk("f_busy", busy, 1'b1);
    cyc();
    mrv = 1'b0; #2;
    chk("f_idle_busy", busy, 1'b0);
    cyc();

    // contention, back-to-back
    ireq = 1'b1; dreq = 1'b1; iaddr = 32'h110; daddr = 32'h210;
    dwe = 1'b0; dbe = 4'hF; mgnt = 1'b1; mrv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      grants[k] = dgt ? 1 : (igt ? 0 : -1);
      exp_g[k]  = RR ? ((k % 2 == 0) ? 1 : 0) : 1;
      cyc();
    end
    for (int k = 0; k < 4; k++) chk($sformatf("contend_g%0d", k), grants[k], exp_g[k]);
    ireq = 1'b0; dreq = 1'b0; mgnt = 1'b0; #2;
    chk("contend_busy", busy, 1'b1);
    cyc();
    mrv = 1'b0; cyc();

    // store held off by grant for three cycles
    dreq = 1'b1; dwe = 1'b1; dbe = 4'b0011; daddr = 32'h204; dwdata = 32'h1234;
    mgnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mgnt = 1'b1;
      #2;
      chk("st_req", mreq, 1'b1); chk("st_addr", maddr, 32'h204);
      chk("st_be", mbe, 4'b0011); chk("st_wdata", mwdata, 32'h1234);
      chk("st_we", mwe, 1'b1); chk("st_gnt", dgt, k == 3); chk("st_busy", busy, 1'b0);
      cyc();
    end
    dreq = 1'b0; mgnt = 1'b0; mrv = 1'b1; mrdata = 32'h0; #2;
    chk("st_rvalid", drv, 1'b1); chk("st_irvalid", irv, 1'b0);
    cyc();
    mrv = 1'b0; cyc();

    // waiting fetch is not displaced by a later load
    ireq = 1'b1; iaddr = 32'h300; dwe = 1'b0; dbe = 4'hF; #2;
    chk("lk_addr0", maddr, 32'h300);
    cyc();
    dreq = 1'b1; daddr = 32'h400; #2;
    chk("lk_addr1", maddr, 32'h300); chk("lk_dgnt", dgt, 1'b0); chk("lk_we", mwe, 1'b0);
    cyc();
    mgnt = 1'b1; #2;
    chk("lk_igt", igt, 1'b1); chk("lk_dgt", dgt, 1'b0);
    cyc();
    ireq = 1'b0; mrv = 1'b1; #2;
    chk("lk_irv", irv, 1'b1); chk("lk_b2b_dgt", dgt, 1'b1); chk("lk_b2b_addr", maddr, 32'h400);
    cyc();
    dreq = 1'b0; mgnt = 1'b0; #2;
    chk("lk_drv", drv, 1'b1); chk("lk_irv0", irv, 1'b0); chk("lk_busy", busy, 1'b1);
    cyc();
    mrv = 1'b0; cyc();

    // response and new fetch in the same cycle
    dreq = 1'b1; daddr = 32'h500; mgnt = 1'b1; #2;
    chk("b2b_dgt", dgt, 1'b1);
    cyc();
    dreq = 1'b0; ireq = 1'b1; iaddr = 32'h600; mrv = 1'b1; #2;
    chk("b2b_drv", drv, 1'b1); chk("b2b_irv", irv, 1'b0);
    chk("b2b_igt", igt, 1'b1); chk("b2b_busy", busy, 1'b1);
    cyc();
    ireq = 1'b0; mgnt = 1'b0; #2;
    chk("b2b_busy2", busy, 1'b1); chk("b2b_irv2", irv, 1'b1); chk("b2b_drv2", drv, 1'b0);
    cyc();
    mrv = 1'b0; #2;
    chk("b2b_idle", busy, 1'b0);
    cyc();

    // reset while waiting drops the response
    ireq = 1'b1; iaddr = 32'h700; mgnt = 1'b1; #2;
    chk("rw_igt", igt, 1'b1);
    cyc();
    ireq = 1'b0; mgnt = 1'b0; rst = 1'b1; mrv = 1'b1; #2;
    chk("rw_irv_in_rst", irv, 1'b0); chk("rw_req_in_rst", mreq, 1'b0);
    cyc();
    rst = 1'b0; #2;
    chk("rw_irv", irv, 1'b0); chk("rw_drv", drv, 1'b0); chk("rw_busy", busy, 1'b0);
    cyc();
    mrv = 1'b0; cyc();

    // stray response in idle
    mrv = 1'b1; mrdata = 32'hCAFE0001; #2;
    chk("stray_irv", irv, 1'b0); chk("stray_drv", drv, 1'b0); chk("stray_busy", busy, 1'b0);
    cyc();
    mrv = 1'b0; cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
